// File: rtl/serial_chunk_adder_if.sv
// serial_chunk_adder_if: request/result bundle
// between a requester and the chunk adder.
interface serial_chunk_adder_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;

  modport master (
    output start,
    output a,
    output b,
    output cin,
    input  busy,
    input  done,
    input  sum,
    input  cout
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    input  cin,
    output busy,
    output done,
    output sum,
    output cout
  );
endinterface

// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: adds two N-bit operands
// W bits per clock, LSB chunk first.
module serial_chunk_adder #(
  parameter int N = 8,
  parameter int W = 2
) (
  input logic clk,
  input logic rst_n,
  serial_chunk_adder_if.slave bus
);
  localparam int C  = N / W;
  localparam int CW = (C > 1) ? $clog2(C) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [N-1:0]  op_a;
  logic [N-1:0]  op_b;
  logic          carry;
  logic [CW-1:0] cnt;
  logic [N-1:0]  res;
  logic [N-1:0]  sum_q;
  logic          cout_q;
  logic          busy_q;
  logic          done_q;

  logic [W:0]    csum;
  logic [N-1:0]  res_next;
  logic          last;

  // one chunk of the ripple sum plus the
  // result register with the new chunk at the top
  always_comb begin
    csum = {1'b0, op_a[W-1:0]}
         + {1'b0, op_b[W-1:0]}
         + {{W{1'b0}}, carry};
    res_next = (res >> W)
             | (N'(csum[W-1:0]) << (N - W));
    last = (cnt == CW'(C - 1));
  end

  // control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      res    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_a   <= bus.a;
            op_b   <= bus.b;
            carry  <= bus.cin;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        RUN: begin
          res   <= res_next;
          carry <= csum[W];
          op_a  <= op_a >> W;
          op_b  <= op_b >> W;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum_q  <= res_next;
            cout_q <= csum[W];
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= DONE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb_serial_chunk_adder: table, directed and
// random checks of the chunk adder at 8/2 and 4/4.
module tb_serial_chunk_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_chunk_adder_if #(.N(8)) bus8 ();
  serial_chunk_adder_if #(.N(4)) bus4 ();

  serial_chunk_adder #(.N(8), .W(2)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  serial_chunk_adder #(.N(4), .W(4)) u4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
  } vec_t;

  vec_t tbl [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, got, exp);
    end
  endtask

  function automatic logic [8:0] ref8(
    input logic [7:0] x, input logic [7:0] y,
    input logic c);
    return 9'(x) + 9'(y) + 9'(c);
  endfunction

  function automatic logic [4:0] ref4(
    input logic [3:0] x, input logic [3:0] y,
    input logic c);
    return 5'(x) + 5'(y) + 5'(c);
  endfunction

  task automatic add8(input logic [7:0] ta,
                      input logic [7:0] tb_,
                      input logic tc,
                      input logic [8:0] exp,
                      input string nm);
    logic [7:0] held;
    int lat;
    held = bus8.sum;
    bus8.a = ta;
    bus8.b = tb_;
    bus8.cin = tc;
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    bus8.a = 8'($urandom);
    bus8.b = 8'($urandom);
    bus8.cin = 1'($urandom);
    chk({nm, ":busy"}, 32'(bus8.busy), 1);
    lat = 0;
    while (!bus8.done && lat < 20) begin
      chk({nm, ":hold"}, 32'(bus8.sum), 32'(held));
      step();
      lat++;
    end
    chk({nm, ":lat"}, lat, 4);
    chk({nm, ":sum"}, 32'(bus8.sum), 32'(exp[7:0]));
    chk({nm, ":cout"}, 32'(bus8.cout), 32'(exp[8]));
    chk({nm, ":busy_d"}, 32'(bus8.busy), 0);
    step();
    chk({nm, ":pulse"}, 32'(bus8.done), 0);
  endtask

  task automatic add4(input logic [3:0] ta,
                      input logic [3:0] tb_,
                      input logic tc,
                      input logic [4:0] exp,
                      input string nm);
    bus4.a = ta;
    bus4.b = tb_;
    bus4.cin = tc;
    bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
    chk({nm, ":busy"}, 32'(bus4.busy), 1);
    chk({nm, ":early"}, 32'(bus4.done), 0);
    step();
    chk({nm, ":done"}, 32'(bus4.done), 1);
    chk({nm, ":sum"}, 32'(bus4.sum), 32'(exp[3:0]));
    chk({nm, ":cout"}, 32'(bus4.cout), 32'(exp[4]));
    step();
    chk({nm, ":pulse"}, 32'(bus4.done), 0);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic rc;
    logic [3:0] qa;
    logic [3:0] qb;
    int last;
    int pulses;
    int dseen;

    tbl[0] = '{8'h2A, 8'h15, 1'b0, 8'h3F, 1'b0};
    tbl[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    tbl[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[5] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
    tbl[6] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    tbl[7] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0};

    bus8.start = 1'b0;
    bus8.a = '0;
    bus8.b = '0;
    bus8.cin = 1'b0;
    bus4.start = 1'b0;
    bus4.a = '0;
    bus4.b = '0;
    bus4.cin = 1'b0;

    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst8:busy", 32'(bus8.busy), 0);
    chk("rst8:done", 32'(bus8.done), 0);
    chk("rst8:sum", 32'(bus8.sum), 0);
    chk("rst8:cout", 32'(bus8.cout), 0);
    chk("rst4:busy", 32'(bus4.busy), 0);
    chk("rst4:sum", 32'(bus4.sum), 0);

    for (int i = 0; i < 8; i++)
      add8(tbl[i].a, tbl[i].b, tbl[i].cin,
           {tbl[i].c, tbl[i].s},
           $sformatf("tbl%0d", i));

    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      add8(ra, rb, rc, ref8(ra, rb, rc),
           $sformatf("rnd%0d", i));
    end

    // start re-pulsed during the run
    bus8.a = 8'h2A;
    bus8.b = 8'h15;
    bus8.cin = 1'b0;
    bus8.start = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      bus8.a = 8'hC0 + 8'(i);
      bus8.b = 8'h77;
      bus8.cin = 1'b1;
      step();
      chk("ign:busy", 32'(bus8.busy), 1);
    end
    bus8.start = 1'b0;
    step();
    chk("ign:done", 32'(bus8.done), 1);
    chk("ign:sum", 32'(bus8.sum), 32'h3F);
    chk("ign:cout", 32'(bus8.cout), 0);
    step();
    chk("ign:idle", 32'(bus8.busy), 0);

    // start held high: back-to-back runs
    bus8.a = 8'h80;
    bus8.b = 8'h80;
    bus8.cin = 1'b0;
    bus8.start = 1'b1;
    last = -1;
    pulses = 0;
    for (int cyc = 0; cyc < 40 && pulses < 4; cyc++) begin
      step();
      if (bus8.done) begin
        chk("b2b:sum", 32'(bus8.sum), 0);
        chk("b2b:cout", 32'(bus8.cout), 1);
        if (pulses == 0)
          chk("b2b:first", cyc, 4);
        else
          chk("b2b:period", cyc - last, 5);
        last = cyc;
        pulses++;
      end
    end
    chk("b2b:pulses", pulses, 4);
    bus8.start = 1'b0;
    step();
    step();

    // reset in the middle of a run
    add8(8'hC3, 8'h5A, 1'b1,
         ref8(8'hC3, 8'h5A, 1'b1), "pre_rst");
    bus8.a = 8'h2A;
    bus8.b = 8'h15;
    bus8.cin = 1'b0;
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst:busy", 32'(bus8.busy), 0);
    chk("mrst:done", 32'(bus8.done), 0);
    chk("mrst:sum", 32'(bus8.sum), 0);
    chk("mrst:cout", 32'(bus8.cout), 0);
    dseen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus8.done) dseen++;
    end
    chk("mrst:nodone", dseen, 0);
    add8(8'h2A, 8'h15, 1'b0,
         ref8(8'h2A, 8'h15, 1'b0), "post_rst");

    // start on the same edge as reset
    bus8.start = 1'b1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus8.start = 1'b0;
    chk("rst_start:busy", 32'(bus8.busy), 0);
    step();
    chk("rst_start:busy2", 32'(bus8.busy), 0);
    chk("rst_start:done", 32'(bus8.done), 0);

    // single-chunk instance
    add4(4'h9, 4'h8, 1'b1, {1'b1, 4'h2}, "w4_spec");
    add4(4'hF, 4'hF, 1'b1, {1'b1, 4'hF}, "w4_max");
    for (int i = 0; i < 10; i++) begin
      qa = 4'($urandom);
      qb = 4'($urandom);
      rc = 1'($urandom);
      add4(qa, qb, rc, ref4(qa, qb, rc),
           $sformatf("w4rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule
